// File: rtl/alu_seq_if.sv
// Instruction/result handshake bundle for alu_seq.
// The source/sink side uses master; the ALU uses slave.
interface alu_seq_if #(parameter int W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [2*W+2:0]   instruction;
  logic             out_valid;
  logic             out_ready;
  logic [2*W:0]     out;
  logic             err;

  modport master (output in_valid, instruction, out_ready,
                  input  in_ready, out_valid, out, err);
  modport slave  (input  in_valid, instruction, out_ready,
                  output in_ready, out_valid, out, err);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: one instruction in flight, IDLE -> EXEC -> DONE, result held until consumed.
// Build option ALU_SEQ_MUL_EN: opcode 010 runs a W-cycle shift-add multiplier instead of a combinational one.
module alu_seq #(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus
);
  localparam int RW = 2*W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic [RW-1:0] out_r;
  logic          err_r;

  logic [RW-1:0] res;
  logic          res_err;
  logic [W:0]    sum;
  logic [W+1:0]  bias_sum;
  logic [W+7:0]  scaled;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_r;
  assign bus.err       = err_r;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign bias_sum = {2'b0, a} + {2'b0, b} + (W+2)'((1 << W) - 1);
  // Quotient is below 2^(W+5), so the narrowing to RW never drops set bits.
  assign scaled   = {bias_sum, 6'b0} / (W+8)'(7);

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      3'b000: res = RW'(sum);
      3'b001: res = (a > b) ? RW'(a - b) : RW'(b - a);
`ifdef ALU_SEQ_MUL_EN
      3'b010: res = '0;
`else
      3'b010: res = RW'({{W{1'b0}}, a} * {{W{1'b0}}, b});
`endif
      3'b011: res = RW'(scaled);
      3'b100: res = RW'({sum, 2'b00});
      default: res_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc, mcand, pp;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign pp = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      a      <= '0;
      b      <= '0;
      out_r  <= '0;
      err_r  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op    <= bus.instruction[2*W+2:2*W];
          a     <= bus.instruction[2*W-1:W];
          b     <= bus.instruction[W-1:0];
          state <= EXEC;
`ifdef ALU_SEQ_MUL_EN
          acc    <= '0;
          mcand  <= {{W{1'b0}}, bus.instruction[2*W-1:W]};
          mplier <= bus.instruction[W-1:0];
          cnt    <= '0;
`endif
        end
        EXEC: begin
`ifdef ALU_SEQ_MUL_EN
          if (op == 3'b010) begin
            // One multiplier bit per cycle, LSB first; the last bit is folded into the result write.
            acc    <= pp;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(W-1)) begin
              out_r <= RW'(pp);
              err_r <= 1'b0;
              state <= DONE;
            end
          end else begin
            out_r <= res;
            err_r <= res_err;
            state <= DONE;
          end
`else
          out_r <= res;
          err_r <= res_err;
          state <= DONE;
`endif
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();
  alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Returns {err, out} from the opcode table using plain integer arithmetic.
  function automatic logic [2*W+1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = (ia > ib) ? ia - ib : ib - ia;
      3'd2: r = ia * ib;
      3'd3: r = ((ia + ib + (2**W - 1)) * 64) / 7;
      3'd4: r = (ia + ib) * 4;
      default: return {1'b1, {(2*W+1){1'b0}}};
    endcase
    return {1'b0, r[2*W:0]};
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op == 3'd2) ? W + 1 : 2;
`else
    return 2;
`endif
  endfunction

  // Issue one instruction, check latency/result, optionally stall the sink, then consume.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, input string tag);
    int edges;
    logic [2*W+1:0] e;
    e = model(op, a, b);
    @(negedge clk);
    chk($sformatf("%s.rdy", tag), 32'(bus.in_ready), 32'd1);
    bus.out_ready   = (stall == 0);
    bus.in_valid    = 1'b1;
    bus.instruction = {op, a, b};
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.instruction = (2*W+3)'($urandom);
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk($sformatf("%s.lat", tag), 32'(edges), 32'(exp_lat(op)));
    chk($sformatf("%s.out", tag), 32'(bus.out), 32'(e[2*W:0]));
    chk($sformatf("%s.err", tag), 32'(bus.err), 32'(e[2*W+1]));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s.hold", tag), {bus.out_valid, bus.in_ready, bus.err, 20'd0, bus.out},
          {1'b1, 1'b0, e[2*W+1], 20'd0, e[2*W:0]});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s.idle", tag), {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    logic [2*W+1:0] e1, e2;
    int edges;
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset", {29'd0, bus.in_ready, bus.out_valid, bus.err}, 32'b100);
    chk("reset.out", 32'(bus.out), 32'd0);

    do_op(3'd0, 4'd15, 4'd15, 0, "add_max");
    do_op(3'd1, 4'd3,  4'd9,  0, "absd_lt");
    do_op(3'd1, 4'd9,  4'd3,  0, "absd_gt");
    do_op(3'd1, 4'd7,  4'd7,  0, "absd_eq");
    do_op(3'd3, 4'd15, 4'd15, 0, "scale_max");
    do_op(3'd4, 4'd15, 4'd15, 0, "shl_max");
    do_op(3'd3, 4'd0,  4'd0,  0, "scale_zero");
    do_op(3'd2, 4'd15, 4'd15, 0, "mul_max");
    do_op(3'd7, 4'd5,  4'd5,  0, "illegal");
    do_op(3'd0, 4'd1,  4'd2,  0, "after_illegal");

    // Backpressure with a second instruction waiting at the input.
    e1 = model(3'd0, 4'd6, 4'd7);
    e2 = model(3'd4, 4'd2, 4'd3);
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = {3'd0, 4'd6, 4'd7};
    @(posedge clk);
    @(negedge clk);
    bus.instruction = {3'd4, 4'd2, 4'd3};
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("bp.first", 32'(bus.out), 32'(e1[2*W:0]));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold", {bus.out_valid, bus.in_ready, bus.err, 20'd0, bus.out},
          {1'b1, 1'b0, e1[2*W+1], 20'd0, e1[2*W:0]});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.accept", 32'(bus.in_ready), 32'd0);
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("bp.second", {22'd0, bus.err, bus.out}, {22'd0, e2[2*W+1], e2[2*W:0]});
    @(posedge clk);
    @(negedge clk);

    // Reset during execution of a multiply aborts it.
    bus.in_valid    = 1'b1;
    bus.instruction = {3'd2, 4'd15, 4'd15};
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.abort", {bus.in_ready, bus.out_valid, 21'd0, bus.out}, {1'b1, 1'b0, 30'd0});
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) edges++;
    end
    chk("rst.no_result", 32'(edges), 32'd0);

    for (int n = 0; n < 40; n++)
      do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 2),
            $sformatf("rnd%0d", n));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for operand width W. It accepts one instruction at a time over a valid/ready input handshake, executes it in a small state machine, and holds the result on a valid/ready output handshake until it is consumed. It keeps the existing 3-bit opcode set and adds an illegal-opcode flag and flow control. It sits between the instruction source and the result sink, which may stall.

## Interface
- W, default 4: operand width in bits. Legal range 4..16. The result width is 2W+1. The instruction width is 2W+3.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- instruction  in  2W+3  bits [2W+2:2W] are the opcode, [2W-1:W] are operand a, [W-1:0] are operand b. All unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out  out  2W+1  result.
- err  out  1  the current result came from an illegal opcode. Qualified by out_valid.

## Operation
- States:
  - IDLE: in_ready=1.
  - EXEC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE → EXEC when in_valid && in_ready. Opcode, a and b are registered at that edge. Instruction changes after the edge have no effect.
- EXEC → DONE when the computation completes. out and err are registered on the same edge.
- DONE → IDLE when out_ready=1. While out_ready=0, out, err and out_valid hold stable.
- There is no overlap: a new instruction is never accepted in EXEC or DONE.
- Opcodes. All arithmetic is unsigned at full precision, then zero-extended to 2W+1.
  - 000: a+b.
  - 001: |a−b|, computed as a−b if a>b, otherwise b−a. Equal operands give 0.
  - 010: a·b.
  - 011: floor(((a+b+(2^W−1))·64)/7). The maximum is below 2^(W+5), so it always fits.
  - 100: (a+b)<<2.
  - 101, 110, 111: out=0, err=1.
- err=0 for all legal opcodes.
- Reset:
  - Values after reset: state=IDLE, in_ready=1, out_valid=0, out=0, err=0.
  - rst in EXEC or DONE aborts the operation and discards the result. No out_valid pulse follows.
  - rst has priority over every handshake in the same cycle.

## Timing
- Latency is measured from the accepting edge to the first cycle with out_valid=1.
  - Single-step ops: EXEC lasts 1 cycle, so out_valid rises 2 edges after acceptance.
  - Opcode 010 with ALU_SEQ_MUL_EN defined: EXEC lasts W cycles (shift-add, one multiplier bit per cycle, LSB first), so latency is W+1 edges.
- in_ready returns to 1 the cycle after the output handshake edge.
- Minimum issue interval is 3 cycles for single-step ops and W+2 cycles for the iterative multiply.
- in_valid asserted while in_ready=0 is ignored. The source holds it until acceptance.
- out_valid never drops without a handshake, except on rst.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - Opcode 010 uses the iterative W-cycle shift-add multiplier described under Timing.
  - The partial product and counter are internal registers, cleared on rst.
- ALU_SEQ_MUL_EN undefined:
  - Opcode 010 uses a single-cycle combinational multiply, with the same 2-edge latency as the other ops.
  - The multiplier sequencing registers are absent.
- Results are identical in both builds. Only latency differs.

## Test plan
- W=4, out_ready=1, in_valid for one cycle: op 000 a=15 b=15 → out=30, err=0, out_valid 2 edges after acceptance.
- op 001 a=3 b=9 → 6; a=9 b=3 → 6; a=7 b=7 → 0.
- op 011 a=15 b=15 → 411; op 100 a=15 b=15 → 120; op 011 a=0 b=0 → 137.
- op 010 a=15 b=15 → 225:
  - with ALU_SEQ_MUL_EN, out_valid 5 edges after acceptance;
  - without it, 2 edges after acceptance.
- op 111 a=5 b=5 → out=0, err=1. The following legal op 000 a=1 b=2 → out=3, err=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after out_valid rises: out, err and out_valid stay stable, and in_ready=0. A second instruction offered during this time is not accepted.
  - Raise out_ready: IDLE follows, then the second instruction is accepted.
- Pulse rst during EXEC of op 010 (ALU_SEQ_MUL_EN) with a=15 b=15: the next cycle shows in_ready=1, out_valid=0, out=0, and no result ever appears for the aborted op.
